// File: rtl/fpu_add_arb.sv
// Four-way round-robin issue arbiter for a shared FPU add pipeline.
// It bounds outstanding work with credits and can halt and drain for scan-inject sequences.
module fpu_add_arb #(
  parameter int CREDITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [31:0]  req_opcode,
  input  logic [7:0]   req_round_mode,
  input  logic [7:0]   req_cc_id,
  input  logic [255:0] req_operand1,
  input  logic [255:0] req_operand2,
  input  logic         add_done,
  input  logic         halt_req,
  output logic         halted,
  output logic [2:0]   credits_avail,
  output logic [7:0]   opcode,
  output logic [1:0]   round_mode,
  output logic [4:0]   req_id,
  output logic [1:0]   req_cc_id_out,
  output logic [63:0]  operand1,
  output logic [63:0]  operand2,
  output logic         oprd1_50_0_neq_0,
  output logic         oprd1_53_32_neq_0,
  output logic         oprd1_exp_neq_0,
  output logic         oprd1_exp_neq_ff,
  output logic         oprd2_50_0_neq_0,
  output logic         oprd2_53_32_neq_0,
  output logic         oprd2_exp_neq_0,
  output logic         oprd2_exp_neq_ff,
  output logic         add_req
);

  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state_reg;
  logic        halted_reg;
  logic [1:0]  rr_reg;
  logic [2:0]  credits_reg;
  logic [2:0]  tag_reg [4];

  logic        add_req_reg;
  logic [7:0]  opcode_reg;
  logic [1:0]  round_mode_reg;
  logic [4:0]  req_id_reg;
  logic [1:0]  cc_id_reg;
  logic [63:0] operand1_reg;
  logic [63:0] operand2_reg;
  logic [3:0]  flags1_reg;
  logic [3:0]  flags2_reg;

  logic [7:0]  opc_arr [4];
  logic [1:0]  rm_arr  [4];
  logic [1:0]  cc_arr  [4];
  logic [63:0] op1_arr [4];
  logic [63:0] op2_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign opc_arr[gi] = req_opcode[8*gi +: 8];
      assign rm_arr[gi]  = req_round_mode[2*gi +: 2];
      assign cc_arr[gi]  = req_cc_id[2*gi +: 2];
      assign op1_arr[gi] = req_operand1[64*gi +: 64];
      assign op2_arr[gi] = req_operand2[64*gi +: 64];
    end
  endgenerate

  // Packed as {50_0_neq_0, 53_32_neq_0, exp_neq_0, exp_neq_ff}.
  function automatic logic [3:0] opnd_flags(input logic [63:0] v);
    opnd_flags = {|v[50:0], |v[53:32], |v[62:52], ~&v[62:52]};
  endfunction

  logic       win_found;
  logic [1:0] win_idx;
  logic       can_issue;
  logic       grant;
  logic [2:0] next_tag;

  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = rr_reg;
    for (int k = 0; k < 4; k++) begin
      cand = rr_reg + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // halt_req gates issue combinationally so no grant slips through in the cycle it rises.
  assign can_issue = (state_reg == RUN) && !halt_req && (credits_reg != 3'd0);
  assign grant     = can_issue && win_found;
  assign req_ready = grant ? (4'b0001 << win_idx) : 4'b0000;
  assign next_tag  = tag_reg[win_idx] + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg         <= '0;
      add_req_reg    <= 1'b0;
      opcode_reg     <= '0;
      round_mode_reg <= '0;
      req_id_reg     <= '0;
      cc_id_reg      <= '0;
      operand1_reg   <= '0;
      operand2_reg   <= '0;
      flags1_reg     <= '0;
      flags2_reg     <= '0;
      for (int t = 0; t < 4; t++) tag_reg[t] <= '0;
    end else begin
      add_req_reg <= grant;
      if (grant) begin
        rr_reg           <= win_idx + 2'd1;
        tag_reg[win_idx] <= next_tag;
        opcode_reg       <= opc_arr[win_idx];
        round_mode_reg   <= rm_arr[win_idx];
        cc_id_reg        <= cc_arr[win_idx];
        req_id_reg       <= {next_tag, win_idx};
        operand1_reg     <= op1_arr[win_idx];
        operand2_reg     <= op2_arr[win_idx];
        flags1_reg       <= opnd_flags(op1_arr[win_idx]);
        flags2_reg       <= opnd_flags(op2_arr[win_idx]);
      end
    end
  end

  // A credit return at full count is dropped rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_reg <= CRED_MAX;
    end else begin
      case ({grant, add_done})
        2'b10:   credits_reg <= credits_reg - 3'd1;
        2'b01:   if (credits_reg != CRED_MAX) credits_reg <= credits_reg + 3'd1;
        default: credits_reg <= credits_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (halt_req) state_reg <= DRAIN;
          halted_reg <= 1'b0;
        end
        DRAIN: begin
          if (!halt_req) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end else if (credits_reg == CRED_MAX && !add_req_reg) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign halted            = halted_reg;
  assign credits_avail     = credits_reg;
  assign add_req           = add_req_reg;
  assign opcode            = opcode_reg;
  assign round_mode        = round_mode_reg;
  assign req_id            = req_id_reg;
  assign req_cc_id_out     = cc_id_reg;
  assign operand1          = operand1_reg;
  assign operand2          = operand2_reg;
  assign oprd1_50_0_neq_0  = flags1_reg[3];
  assign oprd1_53_32_neq_0 = flags1_reg[2];
  assign oprd1_exp_neq_0   = flags1_reg[1];
  assign oprd1_exp_neq_ff  = flags1_reg[0];
  assign oprd2_50_0_neq_0  = flags2_reg[3];
  assign oprd2_53_32_neq_0 = flags2_reg[2];
  assign oprd2_exp_neq_0   = flags2_reg[1];
  assign oprd2_exp_neq_ff  = flags2_reg[0];

endmodule

// File: doc/fpu_add_arb.md
# fpu_add_arb

Round-robin arbiter and issue sequencer that shares one FPU add pipeline between four request sources. It accepts operand/opcode bundles over per-requester valid/ready handshakes and drives the add-request bus (opcode, round mode, tagged req_id, operands and precomputed operand flags, add_req). It bounds outstanding requests with a credit counter. A halt/drain FSM quiesces the pipeline for scan-inject test sequences.

## Interface
- CREDITS, default 4: maximum add requests outstanding in the FPU add pipe; legal range 1..7.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester grant; transfer when req_valid[i] & req_ready[i].
- req_opcode  in  32  4×8, requester i at [8i+7:8i].
- req_round_mode  in  8  4×2.
- req_cc_id  in  8  4×2.
- req_operand1  in  256  4×64.
- req_operand2  in  256  4×64.
- add_done  in  1  FPU add pipe retired one request (credit return).
- halt_req  in  1  level; request to stop issuing and drain.
- halted  out  1  pipe drained and issue stopped.
- credits_avail  out  3  current credit count.
- opcode  out  8  issued opcode.
- round_mode  out  2  issued round mode.
- req_id  out  5  {tag[2:0], requester index[1:0]}.
- req_cc_id_out  out  2  issued cc id.
- operand1, operand2  out  64 each  issued operands.
- oprd1_50_0_neq_0, oprd1_53_32_neq_0, oprd1_exp_neq_0, oprd1_exp_neq_ff  out  1 each  flags for operand1.
- oprd2_50_0_neq_0, oprd2_53_32_neq_0, oprd2_exp_neq_0, oprd2_exp_neq_ff  out  1 each  flags for operand2.
- add_req  out  1  one-cycle issue strobe.

## Operation
- Arbitration: rotating priority starting at pointer rr (2 bits). The grant goes to the first i in order rr, rr+1, … (mod 4) with req_valid[i]=1. At most one req_ready bit is high per cycle.
- req_ready[i] is combinational and requires all of:
  - state==RUN;
  - halt_req=0;
  - credits_avail>0;
  - i is the winner.
- On a grant to i:
  - rr ← i+1 mod 4;
  - tag[i] ← tag[i]+1 (3-bit, wraps 7→0);
  - the bundle is captured into the output register.
- Flags, computed from the captured operand and registered with it (opndX means operand1 or operand2):
  - 50_0_neq_0 = |opndX[50:0];
  - 53_32_neq_0 = |opndX[53:32];
  - exp_neq_0 = |opndX[62:52];
  - exp_neq_ff = ~&opndX[62:52].
- Credits:
  - issue: decrement;
  - add_done: increment;
  - both in the same cycle: unchanged;
  - add_done while already at CREDITS: ignored, no overflow.
- FSM states RUN, DRAIN, HALTED:
  - RUN → DRAIN when halt_req=1.
  - DRAIN → HALTED when credits_avail==CREDITS and add_req==0.
  - DRAIN → RUN when halt_req=0.
  - HALTED → RUN when halt_req=0.
  - halted = (state==HALTED).

## Timing
- Reset values:
  - add_req, halted, req_ready: 0;
  - all output data fields and flags: 0;
  - credits_avail = CREDITS;
  - rr = 0, tags = 0, state RUN.
- A grant in cycle N produces add_req=1 with valid fields in cycle N+1, for exactly one cycle.
- Back-to-back issue every cycle is possible while credits remain.
- Fields hold their last values while add_req=0.
- Credit latency:
  - add_done in cycle N affects credits_avail from N+1;
  - credits_avail=0 in cycle N blocks every grant in N.
- halt_req rising in cycle N gates req_ready in N; no grant occurs in N.
- halted rises at the earliest one cycle after drain completes, and falls the cycle after halt_req is seen low.
- rst asserted mid-operation returns everything to reset values on the next edge. In-flight credits are forgotten, and the FPU pipe is reset alongside.

## Test plan
- Single request: req_valid=4'b0010, operand1=64'h3FF0_0000_0000_0000, operand2=0 → req_ready=4'b0010 in cycle N. In N+1: add_req=1, req_id=5'b00101, oprd1_exp_neq_0=1, oprd1_exp_neq_ff=1, oprd1_50_0_neq_0=0, oprd2_exp_neq_0=0.
- All four requesters valid continuously, add_done every cycle → grant order 0,1,2,3,0,…; add_req held high; credits_avail steady at CREDITS-1.
- No add_done, all valid, CREDITS=4 → exactly 4 issues, then req_ready=0 and credits_avail=0. One add_done pulse → exactly one more issue, two cycles later.
- Simultaneous issue and add_done at credits_avail=2 → stays 2. Spurious add_done at CREDITS → stays CREDITS.
- Halt with 3 outstanding: assert halt_req → no further grants, halted=0. Three add_done pulses → halted=1 the cycle after the credit count reaches CREDITS. Drop halt_req → halted=0 and issue resumes at rr.
- Tag wrap: requester 3 issued 9 times → req_id tags 1..7,0,1 (req_id[4:2]); rst mid-stream → all outputs 0 and credits_avail=CREDITS on the next cycle.
